// File: rtl/fx_sched.sv
// fx_sched: sample-rate sequencer that feeds a frame through a per-channel filter bank and collects results.
// Optional macro FX_TIMEOUT_EN adds a result timeout (TMO cycles) with raw bypass and a sticky fx_timeout flag.
module fx_sched #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned WIDTH  = 24,
    parameter int unsigned DIV    = 1024,
    parameter int unsigned DEPTH  = 8,
`ifdef FX_TIMEOUT_EN
    parameter int unsigned TMO    = 16,
`endif
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic                    in_valid,
    input  logic                    fx_on,
    output logic [WIDTH-1:0]        fx_data,
    output logic                    fx_wren,
    output logic [CH_W-1:0]         fx_ch,
    output logic                    fx_on_out,
    input  logic [WIDTH-1:0]        fx_res,
    input  logic                    fx_res_valid,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
`ifdef FX_TIMEOUT_EN
    output logic                    fx_timeout,
`endif
    output logic                    overrun
);

    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned FL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE, FLUSH_ISSUE, FLUSH_WAIT, ISSUE, WAIT, DONE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [CH_W-1:0]  ch;
    logic [FL_W-1:0]  fl_cnt;
    logic [WIDTH-1:0] cap     [NUM_CH];
    logic [WIDTH-1:0] slot    [NUM_CH];
    logic [WIDTH-1:0] in_slot [NUM_CH];
    logic             tmo_hit;

    assign tick = (div_cnt == DIV_W'(DIV - 1));

    // Unpacked views of the packed frames keep channel indexing width-exact
    for (genvar k = 0; k < NUM_CH; k++) begin : g_pack
        assign in_slot[k]                   = in_data[k*WIDTH +: WIDTH];
        assign out_data[k*WIDTH +: WIDTH]   = slot[k];
    end

`ifdef FX_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO + 1);
    logic [TMO_W-1:0] tmo_cnt;
    assign tmo_hit = !fx_res_valid && (tmo_cnt == TMO_W'(TMO - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // Write strobes are registered on the edge that enters ISSUE/FLUSH_ISSUE, so they coincide with those states
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            div_cnt   <= '0;
            ch        <= '0;
            fl_cnt    <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cap[k]  <= '0;
                slot[k] <= '0;
            end
            fx_data   <= '0;
            fx_wren   <= 1'b0;
            fx_ch     <= '0;
            fx_on_out <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
`ifdef FX_TIMEOUT_EN
            tmo_cnt    <= '0;
            fx_timeout <= 1'b0;
`endif
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            fx_wren <= 1'b0;
            fx_data <= '0;
            fx_ch   <= '0;
            if (tick && state != IDLE)
                overrun <= 1'b1;
`ifdef FX_TIMEOUT_EN
            if ((state == WAIT || state == FLUSH_WAIT) && !fx_res_valid && !tmo_hit)
                tmo_cnt <= tmo_cnt + 1'b1;
            else
                tmo_cnt <= '0;
            if ((state == WAIT || state == FLUSH_WAIT) && tmo_hit)
                fx_timeout <= 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (tick && in_valid) begin
                        cap     <= in_slot;
                        ch      <= '0;
                        busy    <= 1'b1;
                        fx_wren <= 1'b1;
                        if (fx_on && !fx_on_out) begin
                            fl_cnt <= '0;
                            state  <= FLUSH_ISSUE;
                        end else begin
                            fx_on_out <= fx_on;
                            fx_data   <= in_slot[0];
                            state     <= ISSUE;
                        end
                    end
                end
                FLUSH_ISSUE: state <= FLUSH_WAIT;
                FLUSH_WAIT: begin
                    if (fx_res_valid || tmo_hit) begin
                        fx_wren <= 1'b1;
                        if (fl_cnt < FL_W'(DEPTH - 1)) begin
                            fl_cnt <= fl_cnt + 1'b1;
                            fx_ch  <= ch;
                            state  <= FLUSH_ISSUE;
                        end else if (ch < CH_W'(NUM_CH - 1)) begin
                            ch     <= ch + 1'b1;
                            fl_cnt <= '0;
                            fx_ch  <= ch + 1'b1;
                            state  <= FLUSH_ISSUE;
                        end else begin
                            ch        <= '0;
                            fx_on_out <= 1'b1;
                            fx_data   <= cap[0];
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (fx_res_valid || tmo_hit) begin
                        // On timeout the raw captured sample bypasses the filter
                        slot[ch] <= fx_res_valid ? fx_res : cap[ch];
                        if (ch == CH_W'(NUM_CH - 1)) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            ch      <= ch + 1'b1;
                            fx_wren <= 1'b1;
                            fx_ch   <= ch + 1'b1;
                            fx_data <= cap[ch + 1'b1];
                            state   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fx_sched.sv
// Self-checking bench for fx_sched: randomized frames against a frame-level reference model.
module tb_fx_sched;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned WIDTH  = 24;
    localparam int unsigned DIV    = 80;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned TMO    = 16;
    localparam int unsigned CH_W   = 1;
    localparam int unsigned FW     = NUM_CH * WIDTH;

    logic              clk = 1'b0;
    logic              reset;
    logic [FW-1:0]     in_data;
    logic              in_valid;
    logic              fx_on;
    logic [WIDTH-1:0]  fx_data;
    logic              fx_wren;
    logic [CH_W-1:0]   fx_ch;
    logic              fx_on_out;
    logic [WIDTH-1:0]  fx_res;
    logic              fx_res_valid;
    logic [FW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              overrun;
`ifdef FX_TIMEOUT_EN
    logic              fx_timeout;
`endif

    fx_sched #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DIV(DIV), .DEPTH(DEPTH)
`ifdef FX_TIMEOUT_EN
        , .TMO(TMO)
`endif
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .fx_on(fx_on),
        .fx_data(fx_data), .fx_wren(fx_wren), .fx_ch(fx_ch), .fx_on_out(fx_on_out),
        .fx_res(fx_res), .fx_res_valid(fx_res_valid), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
`ifdef FX_TIMEOUT_EN
        .fx_timeout(fx_timeout),
`endif
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH_W-1:0]  ch;
        logic [WIDTH-1:0] data;
        logic             on;
    } wr_t;

    int  n_chk = 0;
    int  n_fail = 0;
    int  ph;
    int  flt_lat = 1;
    bit  mute_ch1 = 1'b0;
    bit  m_on = 1'b0;
    bit  m_ovr = 1'b0;
    bit  m_tmo = 1'b0;
    int  rd;
    logic [WIDTH-1:0] rdata;
    wr_t act_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample period phase: the tick cycle is the one with ph == DIV-1
    always @(posedge clk or posedge reset)
        if (reset) ph <= 0;
        else       ph <= (ph == DIV - 1) ? 0 : ph + 1;

    // Filter bank model: answers flt_lat cycles after a write; inverts when enabled, echoes when bypassed
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rd    <= 0;
            rdata <= '0;
        end else if (fx_wren) begin
            rd    <= (mute_ch1 && fx_ch == 1'b1) ? 0 : flt_lat;
            rdata <= fx_on_out ? ~fx_data : fx_data;
        end else if (rd > 0) begin
            rd <= rd - 1;
        end
    end
    assign fx_res_valid = (rd == 1);
    assign fx_res       = rdata;

    always @(negedge clk) begin
        if (!reset) begin
            if (fx_wren) act_q.push_back(wr_t'({fx_ch, fx_data, fx_on_out}));
            else         check("bus_idle", 64'({fx_ch, fx_data}), 64'd0);
        end
    end

    task automatic wait_phase(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ph != p && n < 4 * DIV);
    endtask

    task automatic do_frame(input bit v, input bit on, input logic [FW-1:0] d, input int stall);
        wr_t           exp_q[$];
        logic [FW-1:0] exp_out;
        logic [WIDTH-1:0] s;
        bit            flush;
        int            lat;
        wait_phase(DIV - 4);
        in_valid = v;
        fx_on    = on;
        in_data  = d;
        act_q.delete();
        wait_phase(DIV - 1);
        if (!v) begin
            repeat (DIV / 2) @(negedge clk);
            check("skip_writes", 64'(act_q.size()), 64'd0);
            check("skip_on", 64'(fx_on_out), 64'(m_on));
            check("skip_busy", 64'(busy), 64'd0);
            return;
        end
        flush = on && !m_on;
        if (flush) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < DEPTH; k++)
                    exp_q.push_back(wr_t'({CH_W'(c), WIDTH'(0), 1'b0}));
            m_on = 1'b1;
        end else begin
            m_on = on;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            s = d[c*WIDTH +: WIDTH];
            exp_q.push_back(wr_t'({CH_W'(c), s, m_on}));
            if (mute_ch1 && c == 1) begin
                exp_out[c*WIDTH +: WIDTH] = s;
                m_tmo = 1'b1;
            end else begin
                exp_out[c*WIDTH +: WIDTH] = m_on ? ~s : s;
            end
        end
        lat = 0;
        while (!out_valid && lat < 3 * DIV) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_rise", 64'(out_valid), 64'd1);
        if (!flush && flt_lat == 1 && !mute_ch1)
            check("latency", 64'(lat), 64'(2 * NUM_CH + 1));
        check("busy_frame", 64'(busy), 64'd1);
        check("wr_count", 64'(act_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            check($sformatf("wr%0d", i), 64'(act_q[i]), 64'(exp_q[i]));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (ph == DIV - 1) m_ovr = 1'b1;
        end
        check("out_data", 64'(out_data), 64'(exp_out));
        check("out_valid_hold", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        if (ph == DIV - 1) m_ovr = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("out_valid_clr", 64'(out_valid), 64'd0);
        check("busy_clr", 64'(busy), 64'd0);
        check("overrun", 64'(overrun), 64'(m_ovr));
        check("on_out", 64'(fx_on_out), 64'(m_on));
`ifdef FX_TIMEOUT_EN
        check("fx_timeout", 64'(fx_timeout), 64'(m_tmo));
`endif
    endtask

    task automatic reset_test();
        int n;
        logic [FW-1:0] d;
        if (m_on) do_frame(1'b1, 1'b0, FW'({$urandom(), $urandom()}), 0);
        flt_lat = 3;
        wait_phase(DIV - 4);
        in_valid = 1'b1;
        fx_on    = 1'b1;
        in_data  = FW'({$urandom(), $urandom()});
        wait_phase(DIV - 1);
        n = 0;
        while (!fx_wren && n < DIV) begin
            @(negedge clk);
            n++;
        end
        check("flush_started", 64'(fx_wren), 64'd1);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_ctl", 64'({fx_data, fx_wren, fx_ch, fx_on_out, out_valid, busy, overrun}), 64'd0);
        check("rst_mid_data", 64'(out_data), 64'd0);
        d        = FW'({$urandom(), $urandom()});
        in_data  = d;
        fx_on    = 1'b0;
        m_on     = 1'b0;
        m_ovr    = 1'b0;
        m_tmo    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        act_q.delete();
        n = 0;
        while (!fx_wren && n < 2 * DIV) begin
            @(negedge clk);
            n++;
        end
        check("first_tick", 64'(n), 64'(DIV));
        n = 0;
        while (!out_valid && n < 3 * DIV) begin
            @(negedge clk);
            n++;
        end
        check("post_rst_out", 64'(out_data), 64'(d));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("post_rst_ovr", 64'(overrun), 64'd0);
        flt_lat = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        fx_on     = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctl", 64'({fx_data, fx_wren, fx_ch, fx_on_out, out_valid, busy, overrun}), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        reset = 1'b0;

        do_frame(1'b1, 1'b0, {24'hFFFF00, 24'h000100}, 0);   // bypass echo, 2*NUM_CH+1 latency
        do_frame(1'b1, 1'b1, FW'({$urandom(), $urandom()}), 2);   // enable: flush first
        do_frame(1'b1, 1'b1, FW'({$urandom(), $urandom()}), 0);   // stays on, no flush
        do_frame(1'b0, 1'b0, FW'({$urandom(), $urandom()}), 0);   // skipped, request pending
        do_frame(1'b1, 1'b0, FW'({$urandom(), $urandom()}), 1);   // disable applied, no flush
        do_frame(1'b0, 1'b1, FW'({$urandom(), $urandom()}), 0);
        do_frame(1'b1, 1'b1, FW'({$urandom(), $urandom()}), 0);   // re-enable flushes again

        for (int i = 0; i < 12; i++) begin
            flt_lat = $urandom_range(1, 3);
            do_frame($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                     FW'({$urandom(), $urandom()}), $urandom_range(0, 3));
        end
        flt_lat = 1;

        do_frame(1'b1, m_on, FW'({$urandom(), $urandom()}), 100);   // consumer stall across a tick
        do_frame(1'b1, m_on, FW'({$urandom(), $urandom()}), 0);

`ifdef FX_TIMEOUT_EN
        mute_ch1 = 1'b1;
        do_frame(1'b1, 1'b0, FW'({$urandom(), $urandom()}), 0);
        mute_ch1 = 1'b0;
`endif

        reset_test();
        do_frame(1'b1, 1'b0, FW'({$urandom(), $urandom()}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
